invntt: RTL and testbench

Inverse number-theoretic transform for the Kyber768 datapath. It is the decode-side counterpart of the forward `ntt` block. It takes a 256-coefficient polynomial in the NTT domain and returns it to the normal domain, results in the Montgomery domain. It runs seven Gentleman–Sande butterfly stages (len = 2 … 128) on 8 parallel butterfly units, then a final scaling pass by f = 1441. Output is bit-exact with the Kyber round-3 C `invntt`. It sits after pointwise multiplication in decryption and in re-encryption.

---
 rtl/invntt_if.sv | 18 +
 rtl/invntt.sv | 253 +++++++++++++++++++++++++
 tb/tb_invntt.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/invntt_if.sv
// -----------------------------------------------------------------------------
// invntt_if
// Data bus between a polynomial producer/consumer and the invntt block.
//   enable : advance the transform while 1, freeze all state while 0
//   in     : 256 NTT-domain coefficients (signed 16-bit), taken once at load
//   out    : 256 normal-domain coefficients (Montgomery form), held when valid
//   valid  : result ready, stays high until the block is reset
// master = the side that drives enable/in; slave = the invntt block.
// -----------------------------------------------------------------------------
interface invntt_if;
  logic               enable;
  logic signed [15:0] in  [256];
  logic signed [15:0] out [256];
  logic               valid;

  modport master (output enable, output in, input out, input valid);
  modport slave  (input enable, input in, output out, output valid);
endinterface

// File: rtl/invntt.sv
// -----------------------------------------------------------------------------
// invntt
// Kyber768 inverse NTT: seven Gentleman-Sande stages (len = 2 .. 128) on eight
// parallel butterfly lanes, followed by a scaling pass by f = 1441. Results
// are bit-exact with the round-3 reference invntt (Montgomery domain output).
//
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-low; aborts any transform and clears all state
//   bus   : invntt_if.slave (enable, in, out, valid)
//
// Schedule (enabled cycles only)
//   LOAD 1 | 7 x (16 batches x 6 + SYNC 1) | SCALE 32 x 6 | DONE 1
//   valid rises on the 873rd enabled edge after reset release.
//
// Each batch is six cycles: c0 latches the eight multiplier operands (the
// start pulse), c1..c4 let the Montgomery multipliers settle, c5 writes the
// eight results back and steps the batch pointer.
// -----------------------------------------------------------------------------
module invntt (
  input  logic    clk,
  input  logic    reset,
  invntt_if.slave bus
);

  localparam logic signed [15:0] F_SCALE = 16'sd1441;
  // -3327 reinterpreted as an unsigned 16-bit constant (q^-1 mod 2^16).
  localparam logic        [15:0] QINV_U  = 16'd62209;

  // Zeta table in Montgomery form, shared with the forward ntt block.
  // Entry 0 is never used by the inverse transform.
  localparam int ZETAS [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_SYNC,
    ST_SCALE,
    ST_DONE,
    ST_IDLE
  } state_e;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Montgomery multiply: returns a*b*2^-16 mod q in (-q, q).
  function automatic logic signed [15:0] fqmul(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    logic signed [31:0] prod;
    logic        [15:0] t_u;
    logic signed [31:0] t_s;
    logic signed [31:0] red;
    prod = 32'(a) * 32'(b);
    // Only the low 16 bits of prod*qinv matter, so a 16x16 product suffices.
    t_u  = prod[15:0] * QINV_U;
    t_s  = 32'(signed'(t_u));
    // prod - t*q has its low 16 bits at zero by construction.
    red  = prod - t_s * 32'sd3329;
    return 16'(red >>> 16);
  endfunction

  // Barrett reduction to a centred representative of x mod q.
  function automatic logic signed [15:0] barrett(input logic signed [15:0] x);
    logic signed [31:0] x32;
    logic signed [31:0] t32;
    logic signed [31:0] r32;
    x32 = 32'(x);
    t32 = (x32 * 32'sd20159 + 32'sd33554432) >>> 26;
    r32 = x32 - t32 * 32'sd3329;
    return 16'(r32);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic        [2:0]  stage_q;   // 0..6, len = 2 << stage
  logic        [4:0]  batch_q;   // 0..15 in COMPUTE, 0..31 in SCALE
  logic        [2:0]  cyc_q;     // 0..5 within a batch
  logic               valid_q;

  logic signed [15:0] buf_in_q  [256];
  logic signed [15:0] buf_out_q [256];
  logic signed [15:0] out_q     [256];

  // Multiplier operand latches, one pair per lane.
  logic signed [15:0] op_w_q [8];
  logic signed [15:0] op_x_q [8];
  logic signed [15:0] op_w_d [8];
  logic signed [15:0] op_x_d [8];

  // Per-lane addressing and datapath results.
  logic        [6:0]  bfly_n  [8];  // butterfly number within the stage
  logic        [6:0]  grp     [8];  // group number at this len
  logic        [6:0]  off     [8];  // position inside the group
  logic        [6:0]  zidx    [8];  // zeta index for the group
  logic        [7:0]  lo_idx  [8];  // j
  logic        [7:0]  hi_idx  [8];  // j + len
  logic        [7:0]  sc_idx  [8];  // coefficient index in SCALE
  logic signed [15:0] sum_red [8];  // barrett(a + b)
  logic signed [15:0] fq_res  [8];  // multiplier result

  logic               mul_start;

  assign mul_start = (state_q == ST_COMPUTE || state_q == ST_SCALE) && (cyc_q == 3'd0);

  // ---------------------------------------------------------------------------
  // Lane addressing and datapath
  // ---------------------------------------------------------------------------
  // Butterfly n of a stage sits in group n / len at offset n % len, so
  // j = 2*len*group + offset. This one rule yields 4 groups x 2 butterflies per
  // batch at len 2, 2 x 4 at len 4 and 8 contiguous butterflies beyond.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      bfly_n[k]  = {batch_q[3:0], 3'(k)};
      grp[k]     = bfly_n[k] >> (4'(stage_q) + 4'd1);
      off[k]     = bfly_n[k] & (7'd127 >> (3'd6 - stage_q));
      lo_idx[k]  = ({1'b0, grp[k]} << (4'(stage_q) + 4'd2)) | {1'b0, off[k]};
      hi_idx[k]  = lo_idx[k] + (8'd2 << stage_q);
      // 2*(128/len) - 1 - group == (127 >> stage) - group
      zidx[k]    = (7'd127 >> stage_q) - grp[k];
      sc_idx[k]  = {batch_q, 3'(k)};

      // The 16-bit sum wraps before reduction, matching the int16 reference.
      sum_red[k] = barrett(buf_in_q[lo_idx[k]] + buf_in_q[hi_idx[k]]);
      // The operand latches hold still from c0 to c5, so this combinational
      // multiplier is a multicycle path with four spare cycles.
      fq_res[k]  = fqmul(op_w_q[k], op_x_q[k]);

      // NOTE: every output of this block gets a value before any condition
      // can override it, so no path leaves a variable unassigned (no latch).
      op_w_d[k]  = 16'(ZETAS[zidx[k]]);
      op_x_d[k]  = buf_in_q[hi_idx[k]] - buf_in_q[lo_idx[k]];
      if (state_q == ST_SCALE) begin
        op_w_d[k] = F_SCALE;
        op_x_d[k] = buf_in_q[sc_idx[k]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and storage
  // ---------------------------------------------------------------------------
  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge values of the others, exactly like the flops they become.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      stage_q <= 3'd0;
      batch_q <= 5'd0;
      cyc_q   <= 3'd0;
      valid_q <= 1'b0;
      // NOTE: the coefficient buffers are cleared on reset on purpose: an
      // aborted transform must leave no trace on out, so these are flops with
      // reset rather than a RAM macro.
      for (int i = 0; i < 256; i++) begin
        buf_in_q[i]  <= '0;
        buf_out_q[i] <= '0;
        out_q[i]     <= '0;
      end
      for (int k = 0; k < 8; k++) begin
        op_w_q[k] <= '0;
        op_x_q[k] <= '0;
      end
    end else if (bus.enable) begin
      unique case (state_q)
        ST_LOAD: begin
          buf_in_q <= bus.in;
          stage_q  <= 3'd0;
          batch_q  <= 5'd0;
          cyc_q    <= 3'd0;
          state_q  <= ST_COMPUTE;
        end

        ST_COMPUTE, ST_SCALE: begin
          if (mul_start) begin
            for (int k = 0; k < 8; k++) begin
              op_w_q[k] <= op_w_d[k];
              op_x_q[k] <= op_x_d[k];
            end
          end
          if (cyc_q == 3'd5) begin
            cyc_q <= 3'd0;
            for (int k = 0; k < 8; k++) begin
              if (state_q == ST_COMPUTE) begin
                buf_out_q[lo_idx[k]] <= sum_red[k];
                buf_out_q[hi_idx[k]] <= fq_res[k];
              end else begin
                buf_out_q[sc_idx[k]] <= fq_res[k];
              end
            end
            if (state_q == ST_COMPUTE && batch_q == 5'd15) begin
              batch_q <= 5'd0;
              state_q <= ST_SYNC;
            end else if (state_q == ST_SCALE && batch_q == 5'd31) begin
              batch_q <= 5'd0;
              state_q <= ST_DONE;
            end else begin
              batch_q <= batch_q + 5'd1;
            end
          end else begin
            cyc_q <= cyc_q + 3'd1;
          end
        end

        ST_SYNC: begin
          // The finished stage becomes the source of the next one.
          buf_in_q <= buf_out_q;
          if (stage_q == 3'd6) begin
            state_q <= ST_SCALE;
          end else begin
            stage_q <= stage_q + 3'd1;
            state_q <= ST_COMPUTE;
          end
        end

        ST_DONE: begin
          out_q   <= buf_out_q;
          valid_q <= 1'b1;
          state_q <= ST_IDLE;
        end

        ST_IDLE: begin
          // Result is held until the next reset.
        end

        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.out   = out_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_invntt.sv
// -----------------------------------------------------------------------------
// tb_invntt
// Self-checking bench for invntt. The reference is the textbook loop form of
// the Kyber inverse NTT in plain integer arithmetic, plus a forward NTT used
// for the round-trip congruence out == 2^16 * x (mod q).
// -----------------------------------------------------------------------------
module tb_invntt;

  logic clk = 1'b0;
  logic reset;

  invntt_if bus ();

  invntt dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int ZETAS [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  int n_cmp = 0;
  int n_bad = 0;
  int stim [256];
  int expv [256];
  int x_hits = 0;
  int v872;

  // ---------------- reference arithmetic ----------------
  function automatic int s16(input longint v);
    longint m;
    m = v & 64'hFFFF;
    return int'((m >= 32768) ? m - 65536 : m);
  endfunction

  function automatic int mont(input longint a);
    longint t;
    t = s16(a * -3327);
    return int'((a - t * 3329) >>> 16);
  endfunction

  function automatic int fqm(input int a, input int b);
    return mont(longint'(a) * longint'(b));
  endfunction

  function automatic int barr(input int a);
    longint x;
    longint t;
    x = s16(a);
    t = (20159 * x + (1 << 25)) >>> 26;
    return int'(x - t * 3329);
  endfunction

  function automatic void model_invntt();
    int r [256];
    int k;
    for (int i = 0; i < 256; i++) r[i] = s16(stim[i]);
    k = 127;
    for (int len = 2; len <= 128; len = len * 2) begin
      for (int start = 0; start < 256; start = start + 2 * len) begin
        int zeta;
        zeta = ZETAS[k];
        k--;
        for (int j = start; j < start + len; j++) begin
          int t;
          t = r[j];
          r[j] = barr(t + r[j + len]);
          r[j + len] = fqm(zeta, s16(r[j + len] - t));
        end
      end
    end
    for (int i = 0; i < 256; i++) expv[i] = fqm(r[i], 1441);
  endfunction

  // Forward NTT of x followed by a Barrett pass; result goes to stim.
  function automatic void model_ntt(input int x [256]);
    int r [256];
    int k;
    for (int i = 0; i < 256; i++) r[i] = x[i];
    k = 1;
    for (int len = 128; len >= 2; len = len / 2) begin
      for (int start = 0; start < 256; start = start + 2 * len) begin
        int zeta;
        zeta = ZETAS[k];
        k++;
        for (int j = start; j < start + len; j++) begin
          int t;
          t = fqm(zeta, r[j + len]);
          r[j + len] = s16(r[j] - t);
          r[j] = s16(r[j] + t);
        end
      end
    end
    for (int i = 0; i < 256; i++) stim[i] = barr(r[i]);
  endfunction

  // Number of out coefficients differing from expv; first = first bad index.
  function automatic int count_out_diff(output int first);
    int bad;
    bad = 0;
    first = -1;
    for (int i = 0; i < 256; i++) begin
      if (bus.out[i] !== 16'(expv[i])) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    return bad;
  endfunction

  function automatic int count_nonzero_out();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (bus.out[i] !== 16'sd0) bad++;
    return bad;
  endfunction

  // ---------------- stimulus helpers ----------------
  // mode 0: |x| <= 3328, 1: full 16-bit, 2: all 3328, 3: all -3328, 4: zeros
  task automatic gen_stim(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0:       stim[i] = int'($urandom_range(0, 6656)) - 3328;
        1:       stim[i] = s16(longint'($urandom()));
        2:       stim[i] = 3328;
        3:       stim[i] = -3328;
        default: stim[i] = 0;
      endcase
    end
  endtask

  task automatic apply_stim();
    for (int i = 0; i < 256; i++) bus.in[i] = 16'(stim[i]);
  endtask

  task automatic pulse_reset(input logic en);
    reset = 1'b0;
    bus.enable = en;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.enable = 1'b1;
  endtask

  // Runs until valid, a stop edge, or a cycle budget. vedge counts enabled
  // edges since reset release, vphys counts all edges.
  task automatic run_transform(input int stall_at, input int stall_len,
                               input bit rand_en, input int stop_at,
                               output int vedge, output int vphys);
    int n;
    int phys;
    int stalled;
    n = 0;
    phys = 0;
    stalled = 0;
    vedge = -1;
    vphys = -1;
    v872 = -1;
    bus.enable = 1'b1;
    while (vedge < 0 && phys < 3000 && !(stop_at > 0 && n >= stop_at)) begin
      @(posedge clk);
      #1;
      phys++;
      if (bus.enable) n++;
      for (int i = 0; i < 256; i++) if ($isunknown(bus.out[i])) x_hits++;
      if ($isunknown(bus.valid)) x_hits++;
      if (bus.enable && n == 872) v872 = int'(bus.valid);
      if (bus.valid === 1'b1 && vedge < 0) begin
        vedge = n;
        vphys = phys;
      end
      if (stall_at > 0 && n == stall_at && stalled < stall_len) begin
        bus.enable = 1'b0;
        stalled++;
      end else if (rand_en) begin
        bus.enable = ($urandom_range(0, 3) != 0);
      end else begin
        bus.enable = 1'b1;
      end
    end
    bus.enable = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int nz;
    gen_stim(4);
    apply_stim();
    pulse_reset(1'b1);
    n_cmp++;
    if (bus.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid: valid=%b required 0", bus.valid);
    end
    nz = count_nonzero_out();
    n_cmp++;
    if (nz !== 0) begin
      n_bad++;
      $display("FAIL reset_out: %0d nonzero coefficients, required 0", nz);
    end
  endtask

  task automatic test_zeros();
    int ve, vp, first, bad;
    gen_stim(4);
    for (int i = 0; i < 256; i++) expv[i] = 0;
    apply_stim();
    pulse_reset(1'b1);
    run_transform(0, 0, 1'b0, 0, ve, vp);
    n_cmp++;
    if (ve !== 873) begin
      n_bad++;
      $display("FAIL zeros_valid_edge: valid on edge %0d required 873", ve);
    end
    n_cmp++;
    if (v872 !== 0) begin
      n_bad++;
      $display("FAIL zeros_edge_872: valid=%0d required 0", v872);
    end
    bad = count_out_diff(first);
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL zeros_out: %0d differ, out[%0d]=%0d required 0",
               bad, first, bus.out[first]);
    end
  endtask

  task automatic test_golden();
    int ve, vp, first, bad, mode;
    for (int v = 0; v < 12; v++) begin
      mode = (v == 0) ? 2 : (v == 1) ? 3 : (v % 2);
      gen_stim(mode);
      model_invntt();
      apply_stim();
      pulse_reset(1'b1);
      run_transform(0, 0, 1'b0, 0, ve, vp);
      n_cmp++;
      if (ve !== 873) begin
        n_bad++;
        $display("FAIL golden%0d_valid_edge: edge %0d required 873", v, ve);
      end
      bad = count_out_diff(first);
      n_cmp++;
      if (bad !== 0) begin
        n_bad++;
        $display("FAIL golden%0d_out: %0d differ, out[%0d]=%0d required %0d",
                 v, bad, first, bus.out[first], expv[first]);
      end
    end
    n_cmp++;
    if (x_hits !== 0) begin
      n_bad++;
      $display("FAIL no_x_on_out: %0d unknown samples, required 0", x_hits);
    end
  endtask

  task automatic test_round_trip();
    int xv [256];
    int ve, vp, bad, first;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) xv[i] = int'($urandom_range(0, 6656)) - 3328;
      model_ntt(xv);
      apply_stim();
      pulse_reset(1'b1);
      run_transform(0, 0, 1'b0, 0, ve, vp);
      bad = 0;
      first = -1;
      for (int i = 0; i < 256; i++) begin
        if ((int'(bus.out[i]) - 2285 * xv[i]) % 3329 != 0) begin
          if (first < 0) first = i;
          bad++;
        end
      end
      n_cmp++;
      if (bad !== 0) begin
        n_bad++;
        $display("FAIL round_trip%0d: %0d not congruent, out[%0d]=%0d required = 2285*%0d mod 3329",
                 r, bad, first, bus.out[first], xv[first]);
      end
    end
  endtask

  task automatic test_stall();
    int ve, vp, first, bad;
    gen_stim(0);
    model_invntt();
    apply_stim();
    pulse_reset(1'b1);
    run_transform(300, 50, 1'b0, 0, ve, vp);
    n_cmp++;
    if (vp !== 923 || ve !== 873) begin
      n_bad++;
      $display("FAIL stall_valid_edge: physical %0d enabled %0d required 923 / 873", vp, ve);
    end
    bad = count_out_diff(first);
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL stall_out: %0d differ, out[%0d]=%0d required %0d",
               bad, first, bus.out[first], expv[first]);
    end
    // Random enable pattern, stalls land everywhere.
    gen_stim(1);
    model_invntt();
    apply_stim();
    pulse_reset(1'b1);
    run_transform(0, 0, 1'b1, 0, ve, vp);
    n_cmp++;
    if (ve !== 873) begin
      n_bad++;
      $display("FAIL rand_enable_edge: enabled edge %0d required 873", ve);
    end
    bad = count_out_diff(first);
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL rand_enable_out: %0d differ, out[%0d]=%0d required %0d",
               bad, first, bus.out[first], expv[first]);
    end
  endtask

  // Relies on the previous test leaving a completed result in expv/out.
  task automatic test_hold_after_done();
    int bad_cycles, first, last_valid;
    bad_cycles = 0;
    last_valid = 1;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < 256; i++) bus.in[i] = 16'($urandom());
      bus.enable = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      if (bus.valid !== 1'b1 || count_out_diff(first) !== 0) begin
        bad_cycles++;
        last_valid = int'(bus.valid);
      end
    end
    bus.enable = 1'b1;
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++;
      $display("FAIL hold_after_done: %0d cycles changed (valid=%0d), required 0",
               bad_cycles, last_valid);
    end
  endtask

  task automatic test_reset_after_done();
    int nz;
    // Reset with enable low: reset must still win.
    pulse_reset(1'b0);
    n_cmp++;
    if (bus.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_after_done_valid: valid=%b required 0", bus.valid);
    end
    nz = count_nonzero_out();
    n_cmp++;
    if (nz !== 0) begin
      n_bad++;
      $display("FAIL reset_after_done_out: %0d nonzero, required 0", nz);
    end
  endtask

  task automatic test_reset_mid_run();
    int ve, vp, first, bad, nz;
    gen_stim(1);
    apply_stim();
    pulse_reset(1'b1);
    run_transform(0, 0, 1'b0, 400, ve, vp);
    reset = 1'b0;
    @(posedge clk);
    #1;
    nz = count_nonzero_out();
    n_cmp++;
    if (bus.valid !== 1'b0 || nz !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_run_clear: valid=%b nonzero=%0d required 0 / 0", bus.valid, nz);
    end
    gen_stim(0);
    model_invntt();
    apply_stim();
    reset = 1'b1;
    run_transform(0, 0, 1'b0, 0, ve, vp);
    n_cmp++;
    if (ve !== 873) begin
      n_bad++;
      $display("FAIL reset_mid_run_edge: edge %0d required 873", ve);
    end
    bad = count_out_diff(first);
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_run_out: %0d differ, out[%0d]=%0d required %0d",
               bad, first, bus.out[first], expv[first]);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.enable = 1'b1;
    test_reset();
    test_zeros();
    test_golden();
    test_round_trip();
    test_stall();
    test_hold_after_done();
    test_reset_after_done();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
